// File: rtl/debug_snapshot_pkg.sv
// Shared defaults and FSM state type for the frame-synchronous debug snapshot.
package debug_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;
  localparam int V_TRIG_DEF = 480;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/debug_snapshot_if.sv
// CPU debug port, renderer read port and sweep status bundled for the snapshot block.
interface debug_snapshot_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] debug_addr;
  logic [DATA_W-1:0] debug_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  logic              snap_done;
  logic [7:0]        snap_count;

  modport master (
    output debug_addr, rd_data, busy, snap_done, snap_count,
    input  debug_data, rd_addr
  );

  modport slave (
    input  debug_addr, rd_data, busy, snap_done, snap_count,
    output debug_data, rd_addr
  );
endinterface

// File: rtl/debug_snapshot_snap_ram.sv
// Snapshot RAM: one synchronous write port, one registered read-before-write read port.
module snap_ram #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array deliberately unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/debug_snapshot.sv
// Sweeps the CPU debug register file into a local RAM once per frame at vblank start.
module debug_snapshot
  import debug_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int V_TRIG = V_TRIG_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       freeze,
  debug_snapshot_if.master bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [9:0]        V_TRIG_L  = 10'(V_TRIG);

  state_t            state;
  logic              cond_q, cond_d, trigger;
  logic              wr_en_d;
  logic [ADDR_W-1:0] wr_addr_d;
  logic [ADDR_W-1:0] debug_addr;
  logic              busy, snap_done;
  logic [7:0]        snap_count;

  // Edge detect so stalled counters cannot retrigger.
  assign trigger = cond_q & ~cond_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cond_q     <= 1'b0;
      cond_d     <= 1'b0;
      wr_en_d    <= 1'b0;
      wr_addr_d  <= '0;
      debug_addr <= '0;
      busy       <= 1'b0;
      snap_done  <= 1'b0;
      snap_count <= 8'd0;
    end else begin
      cond_q    <= (h_count == 10'd0) && (v_count == V_TRIG_L);
      cond_d    <= cond_q;
      wr_en_d   <= (state == SWEEP);
      wr_addr_d <= debug_addr;
      snap_done <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger && !freeze) begin
            state      <= SWEEP;
            debug_addr <= '0;
            busy       <= 1'b1;
          end
        end
        SWEEP: begin
          // Wraps to 0 after the last address, which is the idle value.
          debug_addr <= debug_addr + 1'b1;
          if (debug_addr == LAST_ADDR) state <= DRAIN;
        end
        DRAIN: begin
          state      <= IDLE;
          busy       <= 1'b0;
          debug_addr <= '0;
          snap_done  <= 1'b1;
          snap_count <= snap_count + 8'd1;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          debug_addr <= '0;
        end
      endcase
    end
  end

  snap_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en_d),
    .wr_addr (wr_addr_d),
    .wr_data (bus.debug_data),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

  assign bus.debug_addr = debug_addr;
  assign bus.busy       = busy;
  assign bus.snap_done  = snap_done;
  assign bus.snap_count = snap_count;
endmodule

// File: tb/tb_debug_snapshot.sv
// Randomized bench for debug_snapshot with a sweep-level reference model and directed literal checks.
module tb_debug_snapshot;
  import debug_pkg::*;

  localparam int AW   = 7;
  localparam int DW   = 32;
  localparam int NREG = 128;
  localparam int VT   = 480;
  localparam int BUSY_LEN = NREG + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] h_count, v_count;
  logic       freeze;
  logic [31:0] key;

  debug_snapshot_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  debug_snapshot #(.ADDR_W(AW), .DATA_W(DW), .V_TRIG(VT)) dut (
    .clk     (clk),
    .rst     (rst),
    .h_count (h_count),
    .v_count (v_count),
    .freeze  (freeze),
    .bus     (bus)
  );

  always #20 clk = ~clk;

  // CPU debug port: returns the value for the address presented on the previous cycle.
  always @(posedge clk) bus.debug_data <= {25'h0, bus.debug_addr} ^ key;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many busy cycles remain in the current sweep.
  int          remaining = 0;
  bit          c1 = 0, c2 = 0;
  int          m_count = 0;
  bit          m_done = 0;
  logic [31:0] m_mem [NREG];
  bit          m_valid [NREG];
  logic [31:0] exp_rd = '0;
  bit          exp_rd_valid = 0;
  bit          live = 0;

  always @(posedge clk) begin : model
    bit trig, idle;
    if (rst) begin
      remaining    = 0;
      c1           = 0;
      c2           = 0;
      m_count      = 0;
      m_done       = 0;
      exp_rd       = '0;
      exp_rd_valid = 1;
      live         = 1;
    end else begin
      trig = c1 && !c2;
      c2   = c1;
      c1   = (h_count == 10'd0) && (v_count == 10'(VT));
      idle = (remaining == 0);
      exp_rd_valid = m_valid[bus.rd_addr];
      exp_rd       = m_mem[bus.rd_addr];
      m_done = (remaining == 1);
      if (remaining > 0) remaining--;
      if (m_done) begin
        m_count = (m_count + 1) % 256;
        for (int a = 0; a < NREG; a++) begin
          m_mem[a]   = 32'(a) ^ key;
          m_valid[a] = 1;
        end
      end
      if (idle && trig && !freeze) begin
        remaining = BUSY_LEN;
        for (int a = 0; a < NREG; a++) m_valid[a] = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    if (live) begin
      chk("busy", 32'(bus.busy), 32'(remaining > 0));
      chk("snap_done", 32'(bus.snap_done), 32'(m_done));
      chk("snap_count", 32'(bus.snap_count), 32'(m_count));
      chk("debug_addr", 32'(bus.debug_addr), (remaining > 1) ? 32'(BUSY_LEN - remaining) : 32'd0);
      if (exp_rd_valid) chk("rd_data", bus.rd_data, exp_rd);
    end
  end

  int busy_cyc = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (bus.busy)      busy_cyc++;
    if (bus.snap_done) done_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    h_count = 10'd0;
    v_count = 10'(VT);
    tick(1);
    v_count = 10'd0;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 10 && !bus.busy; i++) tick(1);
    chk("sweep_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic read_chk(input string name, input logic [AW-1:0] a, input logic [31:0] exp);
    bus.rd_addr = a;
    tick(1);
    chk(name, bus.rd_data, exp);
  endtask

  initial begin
    rst = 1'b1;
    h_count = 10'd0;
    v_count = 10'd0;
    freeze = 1'b0;
    key = 32'hA5A5_0000;
    bus.rd_addr = '0;
    tick(2);
    chk("reset_rd_data", bus.rd_data, 32'd0);
    rst = 1'b0;
    tick(10);
    chk("idle_debug_addr", 32'(bus.debug_addr), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("idle_snap_count", 32'(bus.snap_count), 32'd0);

    // First sweep.
    busy_cyc = 0; done_cnt = 0;
    pulse_trigger();
    tick(140);
    chk("sweep1_busy_len", busy_cyc, 32'd129);
    chk("sweep1_done_pulses", done_cnt, 32'd1);
    chk("sweep1_count", 32'(bus.snap_count), 32'd1);
    read_chk("rd0", 7'd0, 32'hA5A5_0000);
    read_chk("rd5", 7'd5, 32'hA5A5_0005);
    read_chk("rd127", 7'd127, 32'hA5A5_007F);

    // Stalled counters on the trigger position: one sweep only.
    busy_cyc = 0; done_cnt = 0;
    h_count = 10'd0; v_count = 10'(VT);
    tick(300);
    v_count = 10'd0;
    tick(5);
    chk("hold_busy_len", busy_cyc, 32'd129);
    chk("hold_count", 32'(bus.snap_count), 32'd2);

    // Frozen trigger: snapshot kept even though CPU data changed.
    freeze = 1'b1;
    key = 32'h5A5A_1234;
    busy_cyc = 0; done_cnt = 0;
    pulse_trigger();
    tick(140);
    chk("freeze_busy", busy_cyc, 32'd0);
    chk("freeze_done", done_cnt, 32'd0);
    read_chk("freeze_rd5", 7'd5, 32'hA5A5_0005);
    freeze = 1'b0;

    // Reset at sweep cycle 40 aborts; rst is a full reset so the count returns to 0.
    pulse_trigger();
    wait_busy();
    tick(39);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_count", 32'(bus.snap_count), 32'd0);
    tick(3);
    busy_cyc = 0; done_cnt = 0;
    pulse_trigger();
    tick(140);
    chk("resweep_busy_len", busy_cyc, 32'd129);
    chk("resweep_count", 32'(bus.snap_count), 32'd1);
    read_chk("resweep_rd5", 7'd5, 32'h5A5A_1231);

    // Second trigger during the sweep is ignored.
    busy_cyc = 0; done_cnt = 0;
    pulse_trigger();
    wait_busy();
    tick(59);
    pulse_trigger();
    tick(150);
    chk("retrig_busy_len", busy_cyc, 32'd129);
    chk("retrig_done", done_cnt, 32'd1);
    chk("retrig_count", 32'(bus.snap_count), 32'd2);

    // Randomized phase; the compare process checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      h_count = 10'($urandom_range(0, 2));
      case ($urandom_range(0, 3))
        0: v_count = 10'(VT - 1);
        1: v_count = 10'(VT);
        2: v_count = 10'(VT + 1);
        default: v_count = 10'd0;
      endcase
      freeze = ($urandom_range(0, 3) == 0);
      bus.rd_addr = 7'($urandom_range(0, NREG - 1));
      rst = ($urandom_range(0, 599) == 0);
      if (remaining == 0 && $urandom_range(0, 39) == 0) key = $urandom;
      tick(1);
    end
    rst = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
